grn_node_lut: RTL and testbench
===============================

# grn_node_lut

Parametrised gene-regulatory-network node for the Boolean-network accelerator. It evaluates one K-input Boolean update function, held as a runtime-loadable truth table, for C independent state copies. Each copy has its own programmable update divider and a fixed-point (stability) detector. The block replaces the hand-written fixed-function, two-copy nodes: the generator instantiates one per gene and wires neighbour states into `in_s`.

## Interface
- `NUM_INPUTS`, 4: K, number of regulator inputs; the truth table has 2^K entries.
- `NUM_COPIES`, 2: C, number of independent state copies.
- `DIV_W`, 4: width of the per-copy update-divider setting.
- `STB_W`, 8: width of the per-copy unchanged-update counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  load `cfg_lut` into the truth-table register.
- `cfg_lut`  in  2^K  truth table; bit i is the next state for input vector i.
- `reset_nos`  in  1  synchronous network restart for all copies.
- `init_state`  in  C  state loaded per copy on `reset_nos`.
- `div_cfg`  in  C*DIV_W  per-copy divider d; the copy updates on every (d+1)-th start.
- `stb_thr`  in  STB_W  stability threshold shared by all copies.
- `start`  in  C  per-copy evaluation strobe.
- `in_s`  in  C*K  per-copy input vector; bit k of slice c is regulator k.
- `s`  out  C  current state per copy.
- `changed`  out  C  1-cycle pulse when an update flips the state.
- `stable`  out  C  high while the unchanged-update count is at or above `stb_thr`.
- `stb_cnt`  out  C*STB_W  unchanged-update count per copy.

## Operation
- Reset (`rst_n`=0): the truth table, `s`, `changed`, `stable`, `stb_cnt` and all phase counters go to 0.
- `cfg_we`: the truth table takes `cfg_lut` at the clock edge. `cfg_we` is independent of `reset_nos` and `start`.
- `reset_nos` applies to every copy c:
  - s[c] <= init_state[c]
  - phase[c] <= 0
  - stb_cnt[c] <= 0
  - `changed` <= 0
  - `start` in the same cycle is ignored.
- `start[c]` with `reset_nos`=0:
  - If phase[c]==0, this is an update:
    - s[c] <= lut[in_s slice c]
    - phase[c] <= div_cfg[c]
    - changed[c] <= (new != old)
    - stb_cnt[c] <= 0 if the state changed; otherwise stb_cnt[c] + 1, saturating at 2^STB_W-1.
  - If phase[c]!=0, this is a skip: phase[c] <= phase[c]-1 and `changed[c]` <= 0.
- A copy with no start in a cycle holds its state and drives `changed[c]`=0.
- Divider behaviour: d=0 updates on every start; d=1 updates on the 1st, 3rd, 5th … start after `reset_nos`. `div_cfg` is sampled only on update cycles.
- `stable[c]` = (stb_cnt[c] >= stb_thr). It is combinational from registers. With `stb_thr`=0, `stable` is 1 whenever `rst_n` is high.
- Copies are fully independent. No cross-copy arbitration.

## Timing
- Update latency is 1 cycle: `s` and `changed` reflect a start at edge N+1.
- A start and `cfg_we` in the same cycle: the evaluation uses the old table. The new table applies from the next cycle.
- `in_s`, `div_cfg` and `stb_thr` are sampled only at the edge where they are used. No input registering.
- `rst_n` assertion mid-run clears state immediately, with no clock required. Deassertion must be synchronised externally.
- Throughput is one start per copy per cycle. Back-to-back starts are legal.

## Structure
- The shared package `grn_pkg` holds:
  - the `lut_idx` function (K-bit slice to index);
  - the saturating-increment function;
  - localparam `LUT_W = 1<<NUM_INPUTS`.
- Sub-module `grn_copy`, generated C times, holds one copy's state, phase counter, stability counter and change flag. It receives its lookup result from the top.
- The top holds the truth-table register and the C parallel mux reads.

## Test plan
- **Reset/init.** Params K=2, C=2. Sequence: `rst_n` low, then `cfg_lut`=4'b1000 (AND), then `reset_nos` with `init_state`=2'b10. Required: `s`=2'b10, `stb_cnt`=0, `changed`=0.
- **Basic update.** With d=0, in_s copy0=2'b11 and start[0] → s[0]=1 next cycle, `changed[0]`=1. With in_s=2'b01 and start → s[0]=0, `changed[0]`=1.
- **Divider.** With d=1 and in_s=2'b11 from s=0, apply 4 consecutive starts. Required: the update lands on the 1st start and the 3rd start is unchanged. Net: s=1, `changed` pulses once, stb_cnt=1.
- **Stability.** With `stb_thr`=3, apply repeated starts with a constant input giving the same state. Required: `stable` rises after the 3rd unchanged update. stb_cnt saturates at 255 with STB_W=8.
- **Hazards.**
  - `cfg_we` with start in the same cycle → the result uses the old table.
  - `reset_nos` with start in the same cycle → `init_state` wins and phase=0.
- **Async reset mid-run.** Drop `rst_n` between clock edges → all outputs are 0 immediately. After release, `s` stays 0 until `reset_nos`.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared types and helpers for the Boolean-network gene node: truth-table
// indexing and the saturating stability-counter increment.
package grn_pkg;

    localparam int NUM_INPUTS_DEF = 4;
    localparam int LUT_W          = 1 << NUM_INPUTS_DEF;

    // Turns a regulator slice into a truth-table index; bit k of the slice is regulator k.
    function automatic logic [31:0] lut_idx(input logic [31:0] slice, input int k);
        if (k >= 32) begin
            return slice;
        end
        return slice & ((32'd1 << k) - 32'd1);
    endfunction

    // Increments a w-bit count, holding at its all-ones ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/grn_copy.sv
// One independent state copy: Boolean state, update divider phase,
// unchanged-update counter and change pulse.
module grn_copy
    import grn_pkg::*;
#(
    parameter int DIV_W = 4,
    parameter int STB_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset_nos,
    input  logic             init_state,
    input  logic             start,
    input  logic             lut_bit,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [STB_W-1:0] stb_thr,
    output logic             s,
    output logic             changed,
    output logic             stable,
    output logic [STB_W-1:0] stb_cnt
);

    logic [DIV_W-1:0] phase;
    logic [STB_W-1:0] cnt_inc;
    logic             flip;

    assign cnt_inc = STB_W'(sat_inc(32'(stb_cnt), STB_W));
    assign flip    = (lut_bit != s);
    assign stable  = (stb_cnt >= stb_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= 1'b0;
            changed <= 1'b0;
            phase   <= '0;
            stb_cnt <= '0;
        end else if (reset_nos) begin
            s       <= init_state;
            changed <= 1'b0;
            phase   <= '0;
            stb_cnt <= '0;
        end else if (start) begin
            // Phase zero means this start is an update; otherwise it only counts down.
            if (phase == '0) begin
                s       <= lut_bit;
                changed <= flip;
                phase   <= div_cfg;
                stb_cnt <= flip ? '0 : cnt_inc;
            end else begin
                changed <= 1'b0;
                phase   <= phase - 1'b1;
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/grn_node_lut.sv
// Gene node: one runtime-loadable K-input truth table shared by C
// independent state copies, each reading the table through its own mux.
module grn_node_lut
    import grn_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_COPIES = 2,
    parameter int DIV_W      = 4,
    parameter int STB_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [(1<<NUM_INPUTS)-1:0]    cfg_lut,
    input  logic                          reset_nos,
    input  logic [NUM_COPIES-1:0]         init_state,
    input  logic [NUM_COPIES*DIV_W-1:0]   div_cfg,
    input  logic [STB_W-1:0]              stb_thr,
    input  logic [NUM_COPIES-1:0]         start,
    input  logic [NUM_COPIES*NUM_INPUTS-1:0] in_s,
    output logic [NUM_COPIES-1:0]         s,
    output logic [NUM_COPIES-1:0]         changed,
    output logic [NUM_COPIES-1:0]         stable,
    output logic [NUM_COPIES*STB_W-1:0]   stb_cnt
);

    logic [(1<<NUM_INPUTS)-1:0] lut;
    logic [NUM_COPIES-1:0]      lut_bit;

    // The copies read the registered table, so a same-cycle load only affects later starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut <= '0;
        end else if (cfg_we) begin
            lut <= cfg_lut;
        end
    end

    for (genvar c = 0; c < NUM_COPIES; c++) begin : g_copy
        logic [NUM_INPUTS-1:0] idx;

        assign idx        = NUM_INPUTS'(lut_idx(32'(in_s[c*NUM_INPUTS +: NUM_INPUTS]), NUM_INPUTS));
        assign lut_bit[c] = lut[idx];

        grn_copy #(
            .DIV_W (DIV_W),
            .STB_W (STB_W)
        ) u_copy (
            .clk        (clk),
            .rst_n      (rst_n),
            .reset_nos  (reset_nos),
            .init_state (init_state[c]),
            .start      (start[c]),
            .lut_bit    (lut_bit[c]),
            .div_cfg    (div_cfg[c*DIV_W +: DIV_W]),
            .stb_thr    (stb_thr),
            .s          (s[c]),
            .changed    (changed[c]),
            .stable     (stable[c]),
            .stb_cnt    (stb_cnt[c*STB_W +: STB_W])
        );
    end

endmodule

// File: tb/tb_grn_node_lut.sv
// Directed bench for grn_node_lut with K=2, C=2: expected outputs are queued
// by the driver and compared by an independent monitor one edge later.
module tb_grn_node_lut;

    localparam int K  = 2;
    localparam int C  = 2;
    localparam int DW = 4;
    localparam int SW = 8;
    localparam int OW = C + C + C*SW + C;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_we = 1'b0;
    logic [(1<<K)-1:0] cfg_lut = '0;
    logic            reset_nos = 1'b0;
    logic [C-1:0]    init_state = '0;
    logic [C*DW-1:0] div_cfg = '0;
    logic [SW-1:0]   stb_thr = 8'd3;
    logic [C-1:0]    start = '0;
    logic [C*K-1:0]  in_s = '0;
    logic [C-1:0]    s;
    logic [C-1:0]    changed;
    logic [C-1:0]    stable;
    logic [C*SW-1:0] stb_cnt;

    logic [OW-1:0] exp_q[$];
    string         name_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [OW-1:0] obs;

    assign obs = {s, changed, stb_cnt, stable};

    grn_node_lut #(
        .NUM_INPUTS (K),
        .NUM_COPIES (C),
        .DIV_W      (DW),
        .STB_W      (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_lut    (cfg_lut),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .div_cfg    (div_cfg),
        .stb_thr    (stb_thr),
        .start      (start),
        .in_s       (in_s),
        .s          (s),
        .changed    (changed),
        .stable     (stable),
        .stb_cnt    (stb_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] mk(input logic [1:0] es, input logic [1:0] ech,
                                         input logic [7:0] c1, input logic [7:0] c0,
                                         input logic [1:0] estb);
        return {es, ech, c1, c0, estb};
    endfunction

    task automatic check(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got s=%b ch=%b cnt=%h stable=%b, expected s=%b ch=%b cnt=%h stable=%b",
                     nm, got[21:20], got[19:18], got[17:2], got[1:0],
                     want[21:20], want[19:18], want[17:2], want[1:0]);
        end
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), obs, exp_q.pop_front());
            end
        end
    end

    // driver: called at a negedge, result is checked just after the following posedge
    task automatic drive(input logic cw, input logic [3:0] lut, input logic rn,
                         input logic [1:0] init, input logic [1:0] st, input logic [3:0] ins,
                         input logic [7:0] div, input logic [OW-1:0] exp_v, input string nm);
        cfg_we     = cw;
        cfg_lut    = lut;
        reset_nos  = rn;
        init_state = init;
        start      = st;
        in_s       = ins;
        div_cfg    = div;
        exp_q.push_back(exp_v);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        #1;
        check("reset_state", obs, mk(2'b00, 2'b00, 8'd0, 8'd0, 2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset / init
        drive(1, 4'b1000, 0, 2'b00, 2'b00, 4'b0000, 8'h00, mk(2'b00, 2'b00, 0, 0, 2'b00), "cfg_load");
        drive(0, 4'b0000, 1, 2'b10, 2'b00, 4'b0000, 8'h00, mk(2'b10, 2'b00, 0, 0, 2'b00), "reset_nos_init");
        // basic update
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b11, 2'b01, 0, 0, 2'b00), "upd_and_11");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0001, 8'h00, mk(2'b10, 2'b01, 0, 0, 2'b00), "upd_and_01");
        // divider d=1
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h01, mk(2'b11, 2'b01, 0, 0, 2'b00), "div_start1");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h01, mk(2'b11, 2'b00, 0, 0, 2'b00), "div_start2");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h01, mk(2'b11, 2'b00, 0, 1, 2'b00), "div_start3");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h01, mk(2'b11, 2'b00, 0, 1, 2'b00), "div_start4");
        // stability with threshold 3
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b11, 2'b00, 0, 2, 2'b00), "stb_cnt2");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b11, 2'b00, 0, 3, 2'b01), "stb_rise");
        for (int i = 1; i <= 253; i++) begin
            cnt = (3 + i > 255) ? 255 : 3 + i;
            drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00,
                  mk(2'b11, 2'b00, 0, 8'(cnt), 2'b01), "stb_sat");
        end
        stb_thr = 8'd0;
        drive(0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000, 8'h00, mk(2'b11, 2'b00, 0, 255, 2'b11), "thr_zero");
        stb_thr = 8'd3;
        // independent copies
        drive(0, 4'b0000, 0, 2'b00, 2'b11, 4'b1100, 8'h00, mk(2'b10, 2'b01, 1, 0, 2'b00), "indep");
        // cfg_we hazard: load NAND while starting
        drive(1, 4'b0111, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b11, 2'b01, 1, 0, 2'b00), "cfg_hazard_old");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b10, 2'b01, 1, 0, 2'b00), "cfg_hazard_new");
        // reset_nos hazard: leave phase at 2, then restart with concurrent starts
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0000, 8'h02, mk(2'b11, 2'b01, 1, 0, 2'b00), "pre_rst_upd");
        drive(0, 4'b0000, 1, 2'b01, 2'b11, 4'b1111, 8'h00, mk(2'b01, 2'b00, 0, 0, 2'b00), "rst_nos_wins");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0011, 8'h00, mk(2'b00, 2'b01, 0, 0, 2'b00), "phase_cleared");
        drive(0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000, 8'h00, mk(2'b00, 2'b00, 0, 0, 2'b00), "idle_hold");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0000, 8'h00, mk(2'b01, 2'b01, 0, 0, 2'b00), "pre_async");

        // async reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", obs, mk(2'b00, 2'b00, 0, 0, 2'b00));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'b0000, 0, 2'b00, 2'b00, 4'b0000, 8'h00, mk(2'b00, 2'b00, 0, 0, 2'b00), "post_async_hold");
        drive(0, 4'b0000, 0, 2'b00, 2'b01, 4'b0000, 8'h00, mk(2'b00, 2'b00, 0, 1, 2'b00), "lut_cleared");
        drive(0, 4'b0000, 1, 2'b11, 2'b00, 4'b0000, 8'h00, mk(2'b11, 2'b00, 0, 0, 2'b00), "post_async_init");

        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
